cbus_mem_req_seq: RTL

- CBUS-side request sequencer, directly upstream of the two-port-memory arbiter top.
- Accepts single read/write commands from a host valid/ready port and drives `cbus_req`/`cbus_slv_cmd`/address/wdata to the arbiter.
- Holds the request until the arbiter grants it, since PHY traffic has priority and can stall CBUS indefinitely.
- Captures `cbus_rddata` (valid the cycle after `cbus_rresp`) and returns a one-cycle response to the host. One transaction outstanding at a time.

---
 rtl/cbus_mem_req_seq_if.sv | 36 +++
 rtl/cbus_mem_req_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cbus_mem_req_seq_if.sv
// rtl/cbus_mem_req_seq_if.sv - host command/response and CBUS request signal bundle for cbus_mem_req_seq
// slave = sequencer view, master = host/arbiter environment view.
interface cbus_mem_req_seq_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          host_valid;
  logic          host_ready;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_rdata;
  logic          host_rsp_err;
  logic          cbus_req;
  logic          cbus_slv_cmd;
  logic [AW-1:0] cbus_slv_address;
  logic [DW-1:0] cbus_slv_wdata;
  logic          cbus_waccept;
  logic          cbus_rresp;
  logic [31:0]   cbus_rddata;

  modport slave (
    input  host_valid, host_wr, host_addr, host_wdata,
    input  cbus_waccept, cbus_rresp, cbus_rddata,
    output host_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
    output cbus_req, cbus_slv_cmd, cbus_slv_address, cbus_slv_wdata
  );

  modport master (
    output host_valid, host_wr, host_addr, host_wdata,
    output cbus_waccept, cbus_rresp, cbus_rddata,
    input  host_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
    input  cbus_req, cbus_slv_cmd, cbus_slv_address, cbus_slv_wdata
  );
endinterface

// File: rtl/cbus_mem_req_seq.sv
// rtl/cbus_mem_req_seq.sv - single-outstanding CBUS request sequencer in front of the two-port-memory arbiter
// Optional request timeout enabled by defining CBUS_REQ_TIMEOUT_EN.
module cbus_mem_req_seq #(
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int CNTW      = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            sreset_n,
  cbus_mem_req_seq_if.slave bus,
  output logic [CNTW-1:0] wr_done_cnt,
  output logic [CNTW-1:0] rd_done_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_DATA = 3'd3,
    S_RSP     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_wr_done;
  logic            w_timeout;
  logic            w_to_hit;
  logic            r_cbus_req;
  logic            r_cbus_cmd;
  logic [AW-1:0]   r_cbus_addr;
  logic [DW-1:0]   r_cbus_wdata;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic [CNTW-1:0] r_wr_cnt;
  logic [CNTW-1:0] r_rd_cnt;
  logic [DW-1:0]   w_rddata;

  assign w_rddata = bus.cbus_rddata[DW-1:0];

`ifdef CBUS_REQ_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES);

  logic [TOW-1:0] r_to_cnt;
  logic           r_rsp_err;

  // Counts request cycles; zero on every entry because all other states hold it at 0.
  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WR_REQ || r_state == S_RD_REQ) begin
      r_to_cnt <= r_to_cnt + TOW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_to_hit = (r_to_cnt == TOW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if (w_wr_done || r_state == S_RD_DATA) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign bus.host_rsp_err = r_rsp_err;
`else
  assign w_to_hit         = 1'b0;
  assign bus.host_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A grant in the expiry cycle is checked first so it wins over the timeout.
  always_comb begin
    w_next    = r_state;
    w_wr_done = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.host_valid) begin
          w_next = bus.host_wr ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (bus.cbus_waccept) begin
          w_next    = S_RSP;
          w_wr_done = 1'b1;
        end else if (w_to_hit) begin
          w_next    = S_RSP;
          w_timeout = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (bus.cbus_rresp) begin
          w_next = S_RD_DATA;
        end else if (w_to_hit) begin
          w_next    = S_RSP;
          w_timeout = 1'b1;
        end
      end
      S_RD_DATA: w_next = S_RSP;
      S_RSP:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      r_cbus_req   <= 1'b0;
      r_cbus_cmd   <= 1'b0;
      r_cbus_addr  <= '0;
      r_cbus_wdata <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
    end else begin
      r_cbus_req  <= (w_next == S_WR_REQ) || (w_next == S_RD_REQ);
      r_rsp_valid <= (w_next == S_RSP);
      if (r_state == S_IDLE && bus.host_valid) begin
        r_cbus_cmd   <= bus.host_wr;
        r_cbus_addr  <= bus.host_addr;
        r_cbus_wdata <= bus.host_wdata;
      end
      // Response data only changes on the edge entering RSP, so it holds between responses.
      if (w_wr_done) begin
        r_rsp_rdata <= '0;
        r_wr_cnt    <= r_wr_cnt + CNTW'(1);
      end else if (r_state == S_RD_DATA) begin
        r_rsp_rdata <= w_rddata;
        r_rd_cnt    <= r_rd_cnt + CNTW'(1);
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
      end
    end
  end

  assign bus.host_ready       = (r_state == S_IDLE);
  assign bus.host_rsp_valid   = r_rsp_valid;
  assign bus.host_rsp_rdata   = r_rsp_rdata;
  assign bus.cbus_req         = r_cbus_req;
  assign bus.cbus_slv_cmd     = r_cbus_cmd;
  assign bus.cbus_slv_address = r_cbus_addr;
  assign bus.cbus_slv_wdata   = r_cbus_wdata;
  assign wr_done_cnt          = r_wr_cnt;
  assign rd_done_cnt          = r_rd_cnt;

endmodule
